// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 16-bit CPU control path:
//   - state_t      : sequencer FSM state encoding
//   - instr_t      : instruction field layout
//                    opcode[15:13] rs[12:10] rt[9:7] rd[6:4] func[3:0]
//                    imm[6:0] overlays rd/func; jump target is instr[12:0]
//   - HALT_WORD_DEFAULT : encoding that stops execution
//   - sign_extend7 : widen a 7-bit signed immediate to 16 bits
// -----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT,
        ST_FAULT
    } state_t;

    typedef struct packed {
        logic [2:0] opcode;
        logic [2:0] rs;
        logic [2:0] rt;
        logic [2:0] rd;
        logic [3:0] func;
    } instr_t;

    // The opcode field doubles as the page that a jump keeps from the pc.
    localparam int OPCODE_LSB = 13;
    localparam int IMM_MSB    = 6;

    localparam logic [15:0] HALT_WORD_DEFAULT = 16'hFFFF;

    function automatic logic [15:0] sign_extend7(input logic [6:0] imm);
        return {{9{imm[6]}}, imm};
    endfunction

endpackage

// File: rtl/cpu_pc_unit.sv
// -----------------------------------------------------------------------------
// cpu_pc_unit
// Combinational next-pc selection.
//   pc       in  16  current program counter
//   jtarget  in  13  instr[12:0]; imm[6:0] is its low slice
//   jump     in   1  take the in-page jump target
//   branch   in   1  conditional relative branch
//   is_zero  in   1  ALU zero flag qualifying the branch
//   next_pc  out 16  selected successor pc (modulo 2^16)
// -----------------------------------------------------------------------------
module cpu_pc_unit
    import cpu_pkg::*;
(
    input  logic [15:0] pc,
    input  logic [12:0] jtarget,
    input  logic        jump,
    input  logic        branch,
    input  logic        is_zero,
    output logic [15:0] next_pc
);

    logic [15:0] seq_pc;

    assign seq_pc = pc + 16'd1;

    // Jump outranks branch when the decoder asserts both.
    always_comb begin
        if (jump) begin
            next_pc = {pc[15:OPCODE_LSB], jtarget};
        end else if (branch && is_zero) begin
            next_pc = seq_pc + sign_extend7(jtarget[IMM_MSB:0]);
        end else begin
            next_pc = seq_pc;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
// Multi-cycle control FSM for the 16-bit CPU. Owns pc and the instruction
// register and steps FETCH -> DECODE -> EXEC -> (MEM) -> WB.
//   clk, rst_n           clock / asynchronous active-low reset
//   run                  1 = free-run, 0 = single-step
//   step                 one-cycle pulse, starts one instruction from IDLE
//   imem_req/ack/rdata   instruction fetch handshake
//   pc, instr            program counter and latched instruction
//   jump, branch,
//   memwrite, regwrite   level controls from the decoder
//   is_zero              ALU zero flag, sampled in EXEC
//   dmem_req/ack         data write handshake
//   reg_we               one-cycle regfile write strobe (WB)
//   halted, fault        sticky stop indications
//   retired              one-cycle pulse per completed instruction
// -----------------------------------------------------------------------------
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] HALT_WORD = HALT_WORD_DEFAULT,
    parameter int unsigned MAX_WAIT  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        step,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] pc,
    output logic [15:0] instr,
    input  logic        jump,
    input  logic        branch,
    input  logic        memwrite,
    input  logic        regwrite,
    input  logic        is_zero,
    output logic        dmem_req,
    input  logic        dmem_ack,
    output logic        reg_we,
    output logic        halted,
    output logic        fault,
    output logic        retired
);

    // The counter holds the number of ack-less cycles already spent in the
    // current wait state, so the MAX_WAIT-th such cycle is the last one.
    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] pc_q;
    logic [15:0] instr_q;
    logic [15:0] next_pc_q;
    logic [15:0] next_pc;
    logic [3:0]  wait_q;
    logic        timeout;

    cpu_pc_unit u_pc_unit (
        .pc      (pc_q),
        .jtarget (instr_q[12:0]),
        .jump    (jump),
        .branch  (branch),
        .is_zero (is_zero),
        .next_pc (next_pc)
    );

    assign timeout = (wait_q == WAIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Requests and strobes decode straight from state so that an async
    // reset drops them in the same cycle.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        reg_we   = 1'b0;
        retired  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run || step) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_d = ST_DECODE;
                end else if (timeout) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DECODE: begin
                state_d = (instr_q == HALT_WORD) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                state_d = memwrite ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    state_d = ST_WB;
                end else if (timeout) begin
                    state_d = ST_FAULT;
                end
            end
            ST_WB: begin
                reg_we  = regwrite;
                retired = 1'b1;
                state_d = run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT, ST_FAULT: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            next_pc_q <= RESET_PC;
            wait_q    <= '0;
        end else begin
            if (state_d != state_q) begin
                wait_q <= '0;
            end else if (state_q == ST_FETCH || state_q == ST_MEM) begin
                wait_q <= wait_q + 4'd1;
            end
            if (state_q == ST_FETCH && imem_ack) begin
                instr_q <= imem_rdata;
            end
            // Target is captured in EXEC while the decoder and flag are
            // valid, and committed only in WB so a MEM fault leaves pc
            // pointing at the faulting instruction.
            if (state_q == ST_EXEC) begin
                next_pc_q <= next_pc;
            end
            if (state_q == ST_WB) begin
                pc_q <= next_pc_q;
            end
        end
    end

    assign pc     = pc_q;
    assign instr  = instr_q;
    assign halted = (state_q == ST_HALT) || (state_q == ST_FAULT);
    assign fault  = (state_q == ST_FAULT);

endmodule

// File: tb/tb_cpu_sequencer.sv
`timescale 1ns/1ps
module tb_cpu_sequencer;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] HALT_W   = 16'hFFFF;
    localparam int          MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        step;
    logic        imem_req;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] pc;
    logic [15:0] instr;
    logic        jump;
    logic        branch;
    logic        memwrite;
    logic        regwrite;
    logic        is_zero;
    logic        dmem_req;
    logic        dmem_ack;
    logic        reg_we;
    logic        halted;
    logic        fault;
    logic        retired;

    cpu_sequencer #(
        .RESET_PC  (RESET_PC),
        .HALT_WORD (HALT_W),
        .MAX_WAIT  (MAX_WAIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .step       (step),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .instr      (instr),
        .jump       (jump),
        .branch     (branch),
        .memwrite   (memwrite),
        .regwrite   (regwrite),
        .is_zero    (is_zero),
        .dmem_req   (dmem_req),
        .dmem_ack   (dmem_ack),
        .reg_we     (reg_we),
        .halted     (halted),
        .fault      (fault),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    // One instruction as seen from outside: the word, what the decoder says
    // about it, the ALU flag, and how long each memory takes to answer.
    // iw/dw = ack-less cycles before the ack; rst_at = dmem cycle to reset on.
    typedef struct {
        logic [15:0] word;
        bit          j;
        bit          b;
        bit          mw;
        bit          rw;
        bit          z;
        int          iw;
        int          dw;
        int          rst_at;
    } rec_t;

    int          checks = 0;
    int          failures = 0;
    int          retire_count = 0;
    bit          reset_hit = 0;
    logic [15:0] model_pc;
    logic [15:0] last_word;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic rec_t mk(input logic [15:0] w, input bit j, input bit b, input bit mw,
                                input bit rw, input bit z, input int iw, input int dw);
        rec_t r;
        r.word = w; r.j = j; r.b = b; r.mw = mw; r.rw = rw; r.z = z;
        r.iw = iw; r.dw = dw; r.rst_at = 0;
        return r;
    endfunction

    // Successor pc from the architectural rules, in plain integer arithmetic.
    function automatic logic [15:0] ref_next(input logic [15:0] cur, input rec_t r);
        int imm;
        int t;
        if (r.j) return (cur & 16'hE000) | (r.word & 16'h1FFF);
        if (r.b && r.z) begin
            imm = int'(r.word & 16'h007F);
            if (imm >= 64) imm -= 128;
            t = int'(cur) + 1 + imm;
            return 16'(t);
        end
        t = int'(cur) + 1;
        return 16'(t);
    endfunction

    task automatic do_reset();
        rst_n    = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_pc", pc, RESET_PC);
        check_eq("rst_instr", instr, 16'h0000);
        check_eq("rst_ctrl", {imem_req, dmem_req, reg_we, retired, halted, fault}, 6'b0);
        rst_n     = 1'b1;
        model_pc  = RESET_PC;
        last_word = 16'h0000;
    endtask

    // Plays instruction memory, decoder and data memory for one instruction
    // and checks the observable behaviour against the model.
    task automatic do_instr(input rec_t r);
        int cyc;
        int reqc;
        int dreqc;
        int wec;
        int lat;
        int exp_lat;
        bit acked;
        bit done;
        bit flt;
        bit exp_mem_to;
        logic [15:0] exp_pc;

        cyc = 0;
        while (!imem_req && cyc < 20) begin
            imem_ack = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check_eq("fetch_start", imem_req, 1'b1);
        if (!imem_req) return;
        check_eq("fetch_pc", pc, model_pc);

        reqc = 0; acked = 0; lat = 0;
        while (imem_req && !acked && reqc < 40) begin
            reqc++;
            lat++;
            if (reqc == r.iw + 1) begin
                imem_ack   = 1'b1;
                imem_rdata = r.word;
                jump       = r.j;
                branch     = r.b;
                memwrite   = r.mw;
                regwrite   = r.rw;
                is_zero    = r.z;
                acked      = 1;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 16'($urandom);
            end
            @(negedge clk);
            imem_ack = 1'b0;
        end

        if (r.iw + 1 > MAX_WAIT) begin
            check_eq("fetch_timeout_len", reqc, MAX_WAIT);
            check_eq("fetch_fault", fault, 1'b1);
            check_eq("fetch_halted", halted, 1'b1);
            check_eq("fetch_fault_pc", pc, model_pc);
            check_eq("fetch_fault_instr", instr, last_word);
            return;
        end
        check_eq("fetch_len", reqc, r.iw + 1);
        check_eq("instr_latched", instr, r.word);
        last_word = r.word;

        if (r.word == HALT_W) begin
            @(negedge clk);
            check_eq("halt_halted", halted, 1'b1);
            check_eq("halt_fault", fault, 1'b0);
            repeat (4) @(negedge clk);
            check_eq("halt_sticky", {halted, imem_req, retired}, 3'b100);
            check_eq("halt_pc", pc, model_pc);
            return;
        end

        exp_lat = r.iw + 1 + 2 + (r.mw ? r.dw + 1 : 0) + 1;
        dreqc = 0; wec = 0; done = 0; flt = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            if (fault) begin
                flt = 1;
                break;
            end
            lat++;
            imem_ack = 1'($urandom_range(0, 1));
            if (dmem_req) begin
                dreqc++;
                check_eq("no_we_during_mem", reg_we, 1'b0);
                if (r.rst_at != 0 && dreqc == r.rst_at) begin
                    dmem_ack = 1'b0;
                    imem_ack = 1'b0;
                    rst_n    = 1'b0;
                    #1;
                    check_eq("midmem_rst_dreq", dmem_req, 1'b0);
                    check_eq("midmem_rst_pc", pc, RESET_PC);
                    check_eq("midmem_rst_ctrl", {imem_req, reg_we, retired, halted}, 4'b0);
                    reset_hit = 1;
                    return;
                end
                dmem_ack = (dreqc == r.dw + 1);
            end else begin
                dmem_ack = 1'($urandom_range(0, 1));
            end
            if (reg_we) wec++;
            if (retired) begin
                done = 1;
                check_eq("latency", lat, exp_lat);
                check_eq("we_in_wb", reg_we, r.rw);
                check_eq("pc_before_wb", pc, model_pc);
            end
            @(negedge clk);
        end
        dmem_ack = 1'b0;
        imem_ack = 1'b0;

        exp_mem_to = r.mw && (r.dw + 1 > MAX_WAIT);
        check_eq("mem_fault", flt, exp_mem_to);
        if (flt) begin
            check_eq("mem_timeout_len", dreqc, MAX_WAIT);
            check_eq("mem_fault_pc", pc, model_pc);
            check_eq("mem_fault_halted", halted, 1'b1);
            return;
        end
        check_eq("retire_seen", done, 1'b1);
        if (!done) return;
        check_eq("dmem_cycles", dreqc, r.mw ? r.dw + 1 : 0);
        check_eq("we_count", wec, r.rw);
        exp_pc = ref_next(model_pc, r);
        check_eq("next_pc", pc, exp_pc);
        check_eq("retired_one_cycle", retired, 1'b0);
        model_pc = exp_pc;
        retire_count++;
    endtask

    initial begin
        rec_t r;
        int   base;

        rst_n = 1'b0; run = 1'b0; step = 1'b0;
        imem_ack = 1'b0; imem_rdata = 16'h0; dmem_ack = 1'b0;
        jump = 1'b0; branch = 1'b0; memwrite = 1'b0; regwrite = 1'b0; is_zero = 1'b0;

        // Free-run: three ALU ops from a memory that answers one cycle after
        // the request, giving the nominal five-cycle instruction.
        run = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            do_instr(mk(16'h1234 + 16'(i), 0, 0, 0, 1, 0, 1, 0));
            check_eq("alu_pc", pc, 16'(i + 1));
        end
        check_eq("alu_retired", retire_count, 3);

        do_instr(mk(16'h4010, 1, 0, 0, 0, 0, 0, 0));
        check_eq("jump_to_10", pc, 16'h0010);
        do_instr(mk(16'h207E, 0, 1, 0, 0, 1, 0, 0));
        check_eq("branch_taken", pc, 16'h000F);
        do_instr(mk(16'h4010, 1, 0, 0, 0, 0, 0, 0));
        do_instr(mk(16'h207E, 0, 1, 0, 0, 0, 0, 0));
        check_eq("branch_not_taken", pc, 16'h0011);
        do_instr(mk(16'h6123, 1, 1, 0, 0, 1, 0, 0));
        check_eq("jump_over_branch", pc, 16'h0123);
        do_instr(mk(16'h8005, 0, 0, 1, 1, 0, 0, 3));
        check_eq("store_pc", pc, 16'h0124);
        do_instr(mk(16'h4000, 1, 0, 0, 0, 0, 0, 0));
        do_instr(mk(16'h207E, 0, 1, 0, 0, 1, 0, 0));
        check_eq("branch_wrap_down", pc, 16'hFFFF);
        do_instr(mk(16'h1111, 0, 0, 0, 1, 0, 0, 0));
        check_eq("seq_wrap_up", pc, 16'h0000);
        do_instr(mk(16'h207E, 0, 1, 0, 0, 1, 0, 0));
        do_instr(mk(16'h6123, 1, 0, 0, 0, 0, 0, 0));
        check_eq("jump_keeps_page", pc, 16'hE123);

        for (int i = 0; i < 24; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if (w == HALT_W) w = 16'h0000;
            do_instr(mk(w, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3)));
        end
        do_instr(mk(HALT_W, 0, 0, 0, 0, 0, 1, 0));

        // Fetch that is never acknowledged.
        do_reset();
        do_instr(mk(16'h0ABC, 0, 0, 0, 1, 0, 0, 0));
        do_instr(mk(16'h0DEF, 0, 0, 0, 1, 0, 20, 0));
        repeat (4) @(negedge clk);
        check_eq("fault_sticky", {fault, halted, imem_req}, 3'b110);
        check_eq("fault_sticky_pc", pc, 16'h0001);

        // Ack on the last allowed cycle is still accepted.
        do_reset();
        base = retire_count;
        do_instr(mk(16'h0321, 0, 0, 0, 1, 0, 14, 0));
        check_eq("late_ack_retired", retire_count - base, 1);
        check_eq("late_ack_fault", fault, 1'b0);

        // Data write that is never acknowledged.
        do_reset();
        do_instr(mk(16'h8001, 0, 0, 1, 0, 0, 0, 20));
        check_eq("mem_fault_flag", fault, 1'b1);

        // Single-step.
        run = 1'b0;
        do_reset();
        repeat (4) @(negedge clk);
        check_eq("idle_no_req", imem_req, 1'b0);
        base = retire_count;
        for (int k = 0; k < 2; k++) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            do_instr(mk(16'h0100 + 16'(k), 0, 0, 0, 1, 0, 0, 0));
            repeat (4) @(negedge clk);
            check_eq("step_back_idle", imem_req, 1'b0);
        end
        check_eq("step_retired", retire_count - base, 2);
        check_eq("step_pc", pc, 16'h0002);

        // Reset in the middle of a data write.
        run = 1'b1;
        do_reset();
        do_instr(mk(16'h0042, 0, 0, 0, 1, 0, 0, 0));
        r = mk(16'h8002, 0, 0, 1, 1, 0, 0, 10);
        r.rst_at = 3;
        reset_hit = 0;
        base = retire_count;
        do_instr(r);
        check_eq("midmem_reset_reached", reset_hit, 1'b1);
        do_reset();
        check_eq("midmem_no_retire", retire_count - base, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
